fetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word-addressed requests to a variable-latency instruction memory (req/ack).
- Presents the instruction word (IMRD) and PC+1 (PCp1) with a valid flag to IF/ID.
- Honours hazard-unit stall and branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory req/ack, IF/ID outputs.
// Pure wiring, no latency.
// Memory side is req/ack (request held until ack); IF/ID side is held by stall.
interface fetch_unit_if #(
  parameter int PCW = 32,
  parameter int IW  = 32
);
  logic           stall;
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_ack;
  logic [IW-1:0]  imem_rdata;
  logic [IW-1:0]  IMRD;
  logic [PCW-1:0] PCp1;
  logic           fetch_valid;
  logic [31:0]    fetch_count;

  // Fetch unit side
  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, IMRD, PCp1, fetch_valid, fetch_count
  );

  // Environment side: hazard unit, ID redirect, instruction memory, IF/ID
  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, IMRD, PCp1, fetch_valid, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, requests imem, presents IMRD/PCp1 to IF/ID.
// Latency: data passes combinationally in the ack cycle (1 instr/cycle on 0-wait memory).
// Backpressure: stall parks the acked word in hold_buf and drops the request until release.
module fetch_unit #(
  parameter int             PCW      = 32,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int             IW       = 32
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  hold_buf_q, hold_buf_d;
  logic [PCW-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]    fetch_count_q, fetch_count_d;

  logic [PCW-1:0] pc_inc;
  logic           req;
  logic [PCW-1:0] addr;
  logic           vld;
  logic [IW-1:0]  imrd;
  logic [PCW-1:0] pcp1;

  // Wraps modulo 2^PCW, so an all-ones PC rolls over to 0.
  assign pc_inc = pc_q + {{(PCW-1){1'b0}}, 1'b1};

  // State, PC and buffers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      hold_buf_q    <= '0;
      drain_addr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_buf_q    <= hold_buf_d;
      drain_addr_q  <= drain_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next state and output muxing; redirect outranks ack and stall everywhere.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_buf_d    = hold_buf_q;
    drain_addr_d  = drain_addr_q;
    fetch_count_d = fetch_count_q;
    req           = 1'b0;
    addr          = '0;
    vld           = 1'b0;
    imrd          = '0;
    pcp1          = '0;

    case (state_q)
      ST_REQ: begin
        req  = 1'b1;
        addr = pc_q;
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
          // The in-flight request cannot be withdrawn; remember its address
          // so it stays on the bus until the stale ack is swallowed.
          if (!bus.imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (bus.imem_ack) begin
          vld  = 1'b1;
          imrd = bus.imem_rdata;
          pcp1 = pc_inc;
          if (bus.stall) begin
            hold_buf_d = bus.imem_rdata;
            state_d    = ST_HOLD;
          end else begin
            pc_d          = pc_inc;
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
      end

      ST_HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = ST_REQ;
        end else begin
          vld  = 1'b1;
          imrd = hold_buf_q;
          pcp1 = pc_inc;
          if (!bus.stall) begin
            pc_d          = pc_inc;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = ST_REQ;
          end
        end
      end

      ST_DRAIN: begin
        req  = 1'b1;
        addr = drain_addr_q;
        // Latest redirect target wins while the stale response is pending.
        if (bus.redirect) begin
          pc_d = bus.redirect_pc;
        end
        if (bus.imem_ack) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.fetch_valid = vld;
  assign bus.IMRD        = imrd;
  assign bus.PCp1        = pcp1;
  assign bus.fetch_count = fetch_count_q;

endmodule
